arbitro_acciones: RTL
=====================

# arbitro_acciones

Controller that shares the single timed-action resource of the pet (the 5-second care window driving `senal_5segMedicina` / `senal_5segEnergia` and the LED update in `Modos`) between four requesters: Medicina, Energia, Descanso and Animo. It edge-detects each request, queues it, grants one requester at a time in round-robin order, and times the action window in seconds. The window runs faster when `Bot_Test` is high. It sits between the button/sensor conditioning logic and `Modos`.

## Interface
Parameters:
- `CICLOS_SEG`, default 50_000_000: clock cycles per second in normal mode. Must be ≥ 2·`FACTOR_TEST`.
- `SEG_ACCION`, default 5: length of the action window in seconds, range 1..7.
- `FACTOR_TEST`, default 10: speed-up divisor applied when `Bot_Test` = 1.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `Bot_Reset` in 1: synchronous, active-high reset.
- `Bot_Test` in 1: level input; selects the accelerated second.
- `Bot_Medicina` in 1: request level, already synchronized.
- `Bot_Energia` in 1: request level, already synchronized.
- `Entrada_Descanso` in 1: request level, already synchronized.
- `Entrada_Animo` in 1: request level, already synchronized.
- `concedido` out 4: one-hot grant. Bit 0 = Medicina, 1 = Energia, 2 = Descanso, 3 = Animo.
- `ocupado` out 1: high while an action window is running.
- `segundos_rest` out 3: seconds remaining in the current window.
- `accion_fin` out 1: one-cycle pulse when a window ends.
- `senal_5segMedicina` out 1: equals `concedido[0]`.
- `senal_5segEnergia` out 1: equals `concedido[1]`.

## Operation
- **Edge detect:** a previous-value register per request input. A rising edge is `in & ~prev`. A level held high produces exactly one request.
- **Pending latch:** `pendiente[i]` is set on a rising edge of request i and cleared when i is granted. If a set and a clear for the same bit fall in the same cycle, the set wins: the request stays queued.
- **Round-robin:** `puntero` (2 bits) is the first index searched. The search runs `puntero`, `puntero+1`, … mod 4. After a grant ends, `puntero` becomes granted index + 1 mod 4.
- **Period P:** P = `CICLOS_SEG` when `Bot_Test` = 0, and `CICLOS_SEG/FACTOR_TEST` (integer division) when `Bot_Test` = 1.
- **Prescaler:** width $clog2(`CICLOS_SEG`). It counts 0..P−1. P is re-evaluated every cycle. If the prescaler is already ≥ P−1 after `Bot_Test` rises, it wraps on that cycle.
- **FSM states:**
  - REPOSO: `ocupado` = 0, `concedido` = 0. If any `pendiente` bit is set, go to ACTIVO at the next edge. That edge loads `concedido` with the one-hot of the round-robin winner, clears that pending bit, sets `segundos_rest` = `SEG_ACCION` and clears the prescaler.
  - ACTIVO: `ocupado` = 1. On each prescaler wrap, `segundos_rest` decrements. On a wrap with `segundos_rest` = 1, go to FIN.
  - FIN: lasts one cycle. `accion_fin` = 1, `concedido` = 0, `segundos_rest` = 0, `ocupado` = 0, `puntero` updated. Then return to REPOSO.
- **Requests during ACTIVO:** they are queued, including re-requests from the requester currently being served.
- **Reset:** the cycle after `Bot_Reset` is sampled high, everything is zero. This covers outputs, pending bits, prev registers, prescaler, `puntero` (= Medicina) and state (= REPOSO). Reset mid-window aborts it with no `accion_fin` pulse. Reset has priority over all other events.

## Timing
- Request rises before edge k: `pendiente` is visible after edge k, and `concedido` / `ocupado` are visible after edge k+1. Grant latency is therefore 2 cycles from an idle state.
- `ocupado` stays high for exactly `SEG_ACCION`·P cycles when `Bot_Test` is constant.
- `accion_fin` is high on the cycle following the last ACTIVO cycle.
- Back-to-back grants: FIN (1 cycle) plus REPOSO (1 cycle) separate consecutive windows, a 2-cycle gap with `ocupado` = 0.
- All outputs are registered, so there is no combinational path from any input to any output.

## Test plan
Parameters for the bench: `CICLOS_SEG` = 4, `FACTOR_TEST` = 2, `SEG_ACCION` = 5.
- **Reset values:** hold `Bot_Reset` high for 3 cycles, then release → all outputs 0 and `concedido` = 0000.
- **Single request:** `Bot_Medicina` rises before edge k and is held high → `concedido` = 0001 from k+1; `segundos_rest` steps 5,4,3,2,1 every 4 cycles; `ocupado` high for 20 cycles; one `accion_fin` pulse; no second grant despite the held level.
- **All four simultaneous:** all requests rise on the same edge → grants run in the order 0001, 0010, 0100, 1000, each 20 cycles, separated by 2-cycle gaps, with 4 `accion_fin` pulses.
- **Test mode:** `Bot_Test` = 1 with an `Entrada_Animo` edge → `ocupado` high for 10 cycles, `segundos_rest` decrements every 2 cycles.
- **Re-request during own window:** `Bot_Energia` pulses again during its ACTIVO → a second Energia grant follows after the 2-cycle gap, ahead of nothing else pending.
- **Reset mid-window:** assert `Bot_Reset` at the 7th ACTIVO cycle while Descanso is pending → next cycle all outputs 0, the pending request is dropped, no `accion_fin`, and the next grant searches from Medicina.

Source files
------------

// File: rtl/arbitro_acciones.sv
// Round-robin arbiter for the pet's single timed-action window; grant 2 cycles after a request edge.
// No backpressure: requests are edge-latched and queued, served one window at a time.
module arbitro_acciones #(
    parameter int CICLOS_SEG  = 50_000_000,
    parameter int SEG_ACCION  = 5,
    parameter int FACTOR_TEST = 10
) (
    input  logic       clk,
    input  logic       Bot_Reset,
    input  logic       Bot_Test,
    input  logic       Bot_Medicina,
    input  logic       Bot_Energia,
    input  logic       Entrada_Descanso,
    input  logic       Entrada_Animo,
    output logic [3:0] concedido,
    output logic       ocupado,
    output logic [2:0] segundos_rest,
    output logic       accion_fin,
    output logic       senal_5segMedicina,
    output logic       senal_5segEnergia
);
    localparam int PW = $clog2(CICLOS_SEG);
    localparam logic [PW-1:0] LIM_NORMAL = PW'(CICLOS_SEG - 1);
    localparam logic [PW-1:0] LIM_TEST   = PW'(CICLOS_SEG / FACTOR_TEST - 1);
    localparam logic [2:0]    SEG_INI    = 3'(SEG_ACCION);

    typedef enum logic [1:0] {REPOSO, ACTIVO, FIN} estado_t;

    estado_t       estado;
    logic [3:0]    entradas;
    logic [3:0]    previo;
    logic [3:0]    flancos;
    logic [3:0]    pendiente;
    logic [3:0]    limpiar;
    logic [1:0]    puntero;
    logic [1:0]    indice;
    logic [1:0]    desplaz;
    logic [1:0]    ganador;
    logic [PW-1:0] prescaler;
    logic [PW-1:0] limite;
    logic          vuelta;

    assign entradas = {Entrada_Animo, Entrada_Descanso, Bot_Energia, Bot_Medicina};
    assign flancos  = entradas & ~previo;
    assign limite   = Bot_Test ? LIM_TEST : LIM_NORMAL;
    // >= rather than == so a shorter period taking effect mid-count wraps at once
    assign vuelta   = prescaler >= limite;

    // Distance from puntero to the first pending requester, searching upward mod 4
    always_comb begin
        desplaz = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (pendiente[puntero + 2'(j)]) begin
                desplaz = 2'(j);
            end
        end
    end

    assign ganador = puntero + desplaz;
    assign limpiar = (estado == REPOSO && |pendiente) ? (4'b0001 << ganador) : 4'b0000;

    always_ff @(posedge clk) begin
        if (Bot_Reset) begin
            estado        <= REPOSO;
            previo        <= '0;
            pendiente     <= '0;
            puntero       <= '0;
            indice        <= '0;
            prescaler     <= '0;
            concedido     <= '0;
            ocupado       <= 1'b0;
            segundos_rest <= '0;
            accion_fin    <= 1'b0;
        end else begin
            previo     <= entradas;
            // A new edge on the bit being granted keeps it queued
            pendiente  <= (pendiente & ~limpiar) | flancos;
            accion_fin <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (|pendiente) begin
                        estado        <= ACTIVO;
                        concedido     <= 4'b0001 << ganador;
                        indice        <= ganador;
                        ocupado       <= 1'b1;
                        segundos_rest <= SEG_INI;
                        prescaler     <= '0;
                    end
                end
                ACTIVO: begin
                    if (vuelta) begin
                        prescaler <= '0;
                        if (segundos_rest == 3'd1) begin
                            estado        <= FIN;
                            concedido     <= '0;
                            ocupado       <= 1'b0;
                            segundos_rest <= '0;
                            accion_fin    <= 1'b1;
                            puntero       <= indice + 2'd1;
                        end else begin
                            segundos_rest <= segundos_rest - 3'd1;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end
                FIN: begin
                    estado <= REPOSO;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

    assign senal_5segMedicina = concedido[0];
    assign senal_5segEnergia  = concedido[1];

endmodule
